// File: rtl/multi_timer_pkg.sv
// Shared types and elaboration helpers for the multi-channel tick timer.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_e;

  function automatic int unsigned cycles_per_tick(int unsigned freq_mhz, int unsigned tick_us);
    return freq_mhz * tick_us;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: IDLE/RUN/HOLD control, private cycle prescaler and tick down-counter.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned CyclesPerTick = 2,
  parameter int unsigned CountW        = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic              periodic_i,
  input  logic [CountW-1:0] duration_i,
  output logic              done_o,
  output logic              busy_o,
  output logic [CountW-1:0] remaining_o
);

  localparam int unsigned PresW = (CyclesPerTick > 1) ? $clog2(CyclesPerTick) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(CyclesPerTick - 1);

  timer_state_e      state_q, state_d;
  logic [PresW-1:0]  presc_q, presc_d;
  logic [CountW-1:0] remaining_q, remaining_d;
  logic [CountW-1:0] reload_q, reload_d;
  logic              periodic_q, periodic_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    done_d      = 1'b0;

    // Priority: stop beats start, start beats counting (so a restart drops the old expiry).
    if (stop_i) begin
      state_d     = IDLE;
      presc_d     = '0;
      remaining_d = '0;
    end else if (start_i) begin
      presc_d = '0;
      if (duration_i == '0) begin
        state_d     = IDLE;
        remaining_d = '0;
        done_d      = 1'b1;
      end else begin
        state_d     = pause_i ? HOLD : RUN;
        remaining_d = duration_i;
        reload_d    = duration_i;
        periodic_d  = periodic_i;
      end
    end else if (state_q != IDLE) begin
      state_d = pause_i ? HOLD : RUN;
      if (!pause_i) begin
        if (presc_q == PresMax) begin
          presc_d = '0;
          if (remaining_q == CountW'(1)) begin
            done_d = 1'b1;
            if (periodic_q) begin
              remaining_d = reload_q;
            end else begin
              remaining_d = '0;
              state_d     = IDLE;
            end
          end else begin
            remaining_d = remaining_q - CountW'(1);
          end
        end else begin
          presc_d = presc_q + PresW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      done_q      <= done_d;
    end
  end

  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign remaining_o = remaining_q;

endmodule

// File: rtl/multi_timer.sv
// NUM_CH independent tick timers with a registered remaining-ticks readout port.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH              = 4,
  parameter int unsigned CLOCK_FREQUENCY_MHZ = 50,
  parameter int unsigned TICK_US             = 1000,
  parameter int unsigned COUNT_W             = 16,
  localparam int unsigned RD_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH-1:0]          stop,
  input  logic [NUM_CH-1:0]          pause,
  input  logic [NUM_CH-1:0]          periodic,
  input  logic [NUM_CH*COUNT_W-1:0]  duration,
  output logic [NUM_CH-1:0]          done,
  output logic [NUM_CH-1:0]          busy,
  input  logic [RD_W-1:0]            rd_sel,
  output logic [COUNT_W-1:0]         rd_remaining
);

  localparam int unsigned P = cycles_per_tick(CLOCK_FREQUENCY_MHZ, TICK_US);

  if (P == 0) begin : g_bad_period
    $error("multi_timer: cycles per tick must be at least 1");
  end

  logic [NUM_CH-1:0][COUNT_W-1:0] remaining;
  logic [COUNT_W-1:0]             rd_remaining_q, rd_remaining_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    multi_timer_channel #(
      .CyclesPerTick (P),
      .CountW        (COUNT_W)
    ) u_channel (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start[g]),
      .stop_i      (stop[g]),
      .pause_i     (pause[g]),
      .periodic_i  (periodic[g]),
      .duration_i  (duration[g*COUNT_W +: COUNT_W]),
      .done_o      (done[g]),
      .busy_o      (busy[g]),
      .remaining_o (remaining[g])
    );
  end

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    rd_remaining_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == RD_W'(i)) rd_remaining_d = remaining[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_remaining_q <= '0;
    else        rd_remaining_q <= rd_remaining_d;
  end

  assign rd_remaining = rd_remaining_q;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench: elapsed-cycle reference model compared every cycle, plus directed literals.
module tb_multi_timer;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int P   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    start = '0, stop = '0, pause = '0, periodic = '0;
  logic [NCH*CW-1:0] duration = '0;
  logic [NCH-1:0]    done, busy;
  logic [1:0]        rd_sel = '0;
  logic [CW-1:0]     rd_remaining;

  multi_timer #(
    .NUM_CH              (NCH),
    .CLOCK_FREQUENCY_MHZ (1),
    .TICK_US             (2),
    .COUNT_W             (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .periodic     (periodic),
    .duration     (duration),
    .done         (done),
    .busy         (busy),
    .rd_sel       (rd_sel),
    .rd_remaining (rd_remaining)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel counts elapsed unpaused cycles against N*P.
  bit          m_act [NCH];
  bit          m_per [NCH];
  int unsigned m_n   [NCH];
  int unsigned m_cnt [NCH];
  logic [NCH-1:0] m_done;
  logic [CW-1:0]  m_rd;

  function automatic int unsigned m_rem(input int c);
    return m_act[c] ? (m_n[c] - m_cnt[c] / P) : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < NCH; c++) begin
          m_act[c] = 0; m_per[c] = 0; m_n[c] = 0; m_cnt[c] = 0;
        end
        m_done = '0;
        m_rd   = '0;
      end else begin
        m_rd = CW'(m_rem(int'(rd_sel)));
        for (int c = 0; c < NCH; c++) begin
          m_done[c] = 1'b0;
          if (stop[c]) begin
            m_act[c] = 0;
          end else if (start[c]) begin
            m_n[c]   = duration[c*CW +: CW];
            m_cnt[c] = 0;
            m_per[c] = periodic[c];
            if (m_n[c] == 0) begin
              m_act[c]  = 0;
              m_done[c] = 1'b1;
            end else begin
              m_act[c] = 1;
            end
          end else if (m_act[c] && !pause[c]) begin
            m_cnt[c]++;
            if (m_cnt[c] == m_n[c] * P) begin
              m_done[c] = 1'b1;
              if (m_per[c]) m_cnt[c] = 0;
              else          m_act[c] = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic [NCH-1:0] m_busy;
        for (int c = 0; c < NCH; c++) m_busy[c] = m_act[c];
        chk("cmp_done", 32'(done), 32'(m_done));
        chk("cmp_busy", 32'(busy), 32'(m_busy));
        chk("cmp_rd_remaining", 32'(rd_remaining), 32'(m_rd));
      end
    end
  end

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic arm(input int c, input int n, input bit per);
    duration[c*CW +: CW] = CW'(n);
    periodic[c] = per;
    start[c] = 1'b1;
  endtask

  int exp_rd [13];

  initial begin
    exp_rd = '{0, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};
    repeat (3) next_cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_done", 32'(done), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rd", 32'(rd_remaining), 0);
    next_cyc();

    // One-shot ch0, N=5: done in cycle T0+10 only, readout 5,5,4,4,... then 0.
    arm(0, 5, 1'b0);
    next_cyc();
    start = '0;
    for (int k = 0; k <= 12; k++) begin
      chk($sformatf("t1_done0_k%0d", k), 32'(done[0]), 32'(k == 10));
      chk($sformatf("t1_busy0_k%0d", k), 32'(busy[0]), 32'(k < 10));
      chk($sformatf("t1_other_k%0d", k), 32'(done[3:1]), 0);
      chk($sformatf("t1_rd_k%0d", k), 32'(rd_remaining), 32'(exp_rd[k]));
      next_cyc();
    end

    // Periodic ch1, N=3: pulses at T0+6, T0+12; stop at edge T0+14.
    arm(1, 3, 1'b1);
    next_cyc();
    start = '0;
    for (int k = 0; k <= 20; k++) begin
      chk($sformatf("t2_done1_k%0d", k), 32'(done[1]), 32'(k == 6 || k == 12));
      chk($sformatf("t2_busy1_k%0d", k), 32'(busy[1]), 32'(k < 14));
      stop[1] = (k == 13);
      next_cyc();
    end
    stop = '0;

    // Stop on the expiry edge of ch2, then start and stop together.
    arm(2, 4, 1'b0);
    next_cyc();
    start = '0;
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("t3_done2_k%0d", k), 32'(done[2]), 0);
      chk($sformatf("t3_busy2_k%0d", k), 32'(busy[2]), 32'(k < 8));
      stop[2] = (k == 7);
      next_cyc();
    end
    arm(2, 4, 1'b0);
    stop[2] = 1'b1;
    next_cyc();
    start = '0;
    stop = '0;
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("t3b_busy2_k%0d", k), 32'(busy[2]), 0);
      chk($sformatf("t3b_done2_k%0d", k), 32'(done[2]), 0);
      next_cyc();
    end

    // Pause ch3 for seven edges (T0+3..T0+9): done moves from T0+8 to T0+15.
    arm(3, 4, 1'b0);
    next_cyc();
    start = '0;
    for (int k = 0; k <= 17; k++) begin
      chk($sformatf("t4_done3_k%0d", k), 32'(done[3]), 32'(k == 15));
      chk($sformatf("t4_busy3_k%0d", k), 32'(busy[3]), 32'(k < 15));
      pause[3] = (k >= 2 && k <= 8);
      next_cyc();
    end
    pause = '0;

    // Restart ch3 at edge T0+5 with N=2: only the new run expires, at T0+9.
    arm(3, 4, 1'b0);
    next_cyc();
    start = '0;
    for (int k = 0; k <= 14; k++) begin
      chk($sformatf("t4b_done3_k%0d", k), 32'(done[3]), 32'(k == 9));
      chk($sformatf("t4b_busy3_k%0d", k), 32'(busy[3]), 32'(k >= 5 ? k < 9 : 1));
      if (k == 4) arm(3, 2, 1'b0);
      else        start = '0;
      next_cyc();
    end

    // Duration 0: one done in the cycle after the start edge, never busy, periodic ignored.
    arm(0, 0, 1'b1);
    next_cyc();
    start = '0;
    for (int k = 0; k <= 6; k++) begin
      chk($sformatf("t5_done0_k%0d", k), 32'(done[0]), 32'(k == 0));
      chk($sformatf("t5_busy0_k%0d", k), 32'(busy[0]), 0);
      next_cyc();
    end

    // Randomised traffic on all channels, checked by the model every cycle.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 11) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 15) == 0) pause[c] = ~pause[c];
        periodic[c] = $urandom_range(0, 1) != 0;
        duration[c*CW +: CW] = CW'($urandom_range(0, 6));
      end
      rd_sel = 2'($urandom_range(0, 3));
      next_cyc();
    end
    start = '0; stop = '0; pause = '0; periodic = '0; rd_sel = '0;
    repeat (4) next_cyc();

    // Asynchronous reset mid-run clears outputs immediately; nothing fires afterwards.
    for (int c = 0; c < NCH; c++) arm(c, 3, 1'b1);
    next_cyc();
    start = '0;
    repeat (2) next_cyc();
    chk("t6_busy_before", 32'(busy), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_done_async", 32'(done), 0);
    chk("t6_busy_async", 32'(busy), 0);
    chk("t6_rd_async", 32'(rd_remaining), 0);
    repeat (2) next_cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next_cyc();
      chk($sformatf("t6_done_after_k%0d", k), 32'(done), 0);
      chk($sformatf("t6_busy_after_k%0d", k), 32'(busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
